// File: rtl/ctrl_pkg.sv
// Shared opcode/control-vector constants, FSM state encoding and helpers
// for the pipelined control unit.
package ctrl_pkg;

    localparam int OP_BITS  = 7;
    localparam int VEC_BITS = 23;

    localparam logic [OP_BITS-1:0] OP_NOT  = 7'b0010001;
    localparam logic [OP_BITS-1:0] OP_INC  = 7'b0000011;
    localparam logic [OP_BITS-1:0] OP_OUT  = 7'b0011001;
    localparam logic [OP_BITS-1:0] OP_IN   = 7'b0011000;
    localparam logic [OP_BITS-1:0] OP_HLT  = 7'b1100001;
    localparam logic [OP_BITS-1:0] OP_NOP  = 7'b1101000;
    localparam logic [OP_BITS-1:0] OP_SETC = 7'b1100010;
    localparam logic [OP_BITS-1:0] OP_MOV  = 7'b0010101;
    localparam logic [OP_BITS-1:0] OP_ADD  = 7'b0000001;
    localparam logic [OP_BITS-1:0] OP_SUB  = 7'b0001001;
    localparam logic [OP_BITS-1:0] OP_AND  = 7'b0001101;
    localparam logic [OP_BITS-1:0] OP_IADD = 7'b0100000;
    localparam logic [OP_BITS-1:0] OP_LDM  = 7'b0110101;
    localparam logic [OP_BITS-1:0] OP_LDD  = 7'b0100010;

    localparam logic [VEC_BITS-1:0] V_NOT  = 23'b01110111000001001100011;
    localparam logic [VEC_BITS-1:0] V_INC  = 23'b01110110000000001100011;
    localparam logic [VEC_BITS-1:0] V_OUT  = 23'b01100111000001011100011;
    localparam logic [VEC_BITS-1:0] V_IN   = 23'b01111111000001011100011;
    localparam logic [VEC_BITS-1:0] V_HLT  = 23'b00000011000001110000001;
    localparam logic [VEC_BITS-1:0] V_NOP  = 23'b01100111000001110100001;
    localparam logic [VEC_BITS-1:0] V_SETC = 23'b01100111000000011100011;
    localparam logic [VEC_BITS-1:0] V_MOV  = 23'b01110111000001011100011;
    localparam logic [VEC_BITS-1:0] V_ADD  = 23'b01110111000000001100011;
    localparam logic [VEC_BITS-1:0] V_SUB  = 23'b01110111000000101100011;
    localparam logic [VEC_BITS-1:0] V_AND  = 23'b01110111000000111100011;
    localparam logic [VEC_BITS-1:0] V_IADD = 23'b10110111100000001100011;
    localparam logic [VEC_BITS-1:0] V_LDM  = 23'b10110111100001101100011;
    localparam logic [VEC_BITS-1:0] V_LDD  = 23'b10110111100000001110011;

    typedef enum logic [1:0] {RUN, IMM, HALT} state_t;

    // Two-word instructions: the opcode beat is followed by an immediate beat.
    function automatic logic is_imm(input logic [OP_BITS-1:0] op);
        return (op == OP_IADD) || (op == OP_LDM) || (op == OP_LDD);
    endfunction

endpackage

// File: rtl/ctrl_decode_rom.sv
// Combinational opcode-to-control-vector lookup; unknown opcodes map to the
// NOP vector with known=0.
module ctrl_decode_rom
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7,
    parameter int SIG_W    = 23
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic [SIG_W-1:0]    vector,
    output logic                known,
    output logic                is_imm,
    output logic                is_hlt
);

    // Compare at the wider of the two widths so table entries are zero-extended.
    localparam int OW = (OPCODE_W > OP_BITS) ? OPCODE_W : OP_BITS;

    logic [OW-1:0] w_op;
    assign w_op = OW'(opcode);

    always_comb begin
        vector = SIG_W'(V_NOP);
        known  = 1'b1;
        is_hlt = 1'b0;
        case (w_op)
            OW'(OP_NOT):  vector = SIG_W'(V_NOT);
            OW'(OP_INC):  vector = SIG_W'(V_INC);
            OW'(OP_OUT):  vector = SIG_W'(V_OUT);
            OW'(OP_IN):   vector = SIG_W'(V_IN);
            OW'(OP_HLT):  begin vector = SIG_W'(V_HLT); is_hlt = 1'b1; end
            OW'(OP_NOP):  vector = SIG_W'(V_NOP);
            OW'(OP_SETC): vector = SIG_W'(V_SETC);
            OW'(OP_MOV):  vector = SIG_W'(V_MOV);
            OW'(OP_ADD):  vector = SIG_W'(V_ADD);
            OW'(OP_SUB):  vector = SIG_W'(V_SUB);
            OW'(OP_AND):  vector = SIG_W'(V_AND);
            OW'(OP_IADD): vector = SIG_W'(V_IADD);
            OW'(OP_LDM):  vector = SIG_W'(V_LDM);
            OW'(OP_LDD):  vector = SIG_W'(V_LDD);
            default:      known  = 1'b0;
        endcase
        is_imm = known && ctrl_pkg::is_imm(w_op[OP_BITS-1:0]);
    end

endmodule

// File: rtl/ctrl_unit_pipe.sv
// Registered control unit: one-cycle decode with stall/flush, immediate-beat
// consumption, sticky halt, illegal flag and a decoded-instruction counter.
module ctrl_unit_pipe
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7,
    parameter int SIG_W    = 23,
    parameter int CNT_W    = 16,
    parameter bit IMM_EN   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                stall,
    input  logic                flush,
    output logic [SIG_W-1:0]    signals,
    output logic                sig_valid,
    output logic                imm_take,
    output logic                illegal,
    output logic                halted,
    output logic [CNT_W-1:0]    instr_cnt
);

    state_t           r_state, w_state;
    logic [SIG_W-1:0] r_signals, w_signals;
    logic             r_sig_valid, w_sig_valid;
    logic             r_imm_take, w_imm_take;
    logic             r_illegal, w_illegal;
    logic [CNT_W-1:0] r_cnt, w_cnt;

    logic [SIG_W-1:0] w_vec;
    logic             w_known, w_is_imm, w_is_hlt;

    ctrl_decode_rom #(.OPCODE_W(OPCODE_W), .SIG_W(SIG_W)) u_rom (
        .opcode (opcode),
        .vector (w_vec),
        .known  (w_known),
        .is_imm (w_is_imm),
        .is_hlt (w_is_hlt)
    );

    always_comb begin
        w_state     = r_state;
        w_signals   = r_signals;
        w_sig_valid = r_sig_valid;
        w_imm_take  = r_imm_take;
        w_illegal   = r_illegal;
        w_cnt       = r_cnt;
        if (flush) begin
            w_signals   = '0;
            w_sig_valid = 1'b0;
            w_imm_take  = 1'b0;
            w_illegal   = 1'b0;
            if (r_state == IMM) w_state = RUN;
        end else if (!stall) begin
            w_sig_valid = 1'b0;
            w_imm_take  = 1'b0;
            w_illegal   = 1'b0;
            case (r_state)
                RUN: if (instr_valid) begin
                    w_signals   = w_vec;
                    w_sig_valid = 1'b1;
                    w_illegal   = !w_known;
                    w_cnt       = r_cnt + 1'b1;
                    if (w_is_hlt)             w_state = HALT;
                    else if (IMM_EN && w_is_imm) w_state = IMM;
                end
                IMM: if (instr_valid) begin
                    w_imm_take = 1'b1;
                    w_state    = RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_signals   <= '0;
            r_sig_valid <= 1'b0;
            r_imm_take  <= 1'b0;
            r_illegal   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state;
            r_signals   <= w_signals;
            r_sig_valid <= w_sig_valid;
            r_imm_take  <= w_imm_take;
            r_illegal   <= w_illegal;
            r_cnt       <= w_cnt;
        end
    end

    assign signals   = r_signals;
    assign sig_valid = r_sig_valid;
    assign imm_take  = r_imm_take;
    assign illegal   = r_illegal;
    assign halted    = (r_state == HALT);
    assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Directed bench for ctrl_unit_pipe with hand-computed expectations.
module tb_ctrl_unit_pipe;

    localparam int OW = 7;
    localparam int SW = 23;
    localparam int CW = 4;

    localparam logic [SW-1:0] E_ADD  = 23'b01110111000000001100011;
    localparam logic [SW-1:0] E_LDM  = 23'b10110111100001101100011;
    localparam logic [SW-1:0] E_SUB  = 23'b01110111000000101100011;
    localparam logic [SW-1:0] E_IADD = 23'b10110111100000001100011;
    localparam logic [SW-1:0] E_NOT  = 23'b01110111000001001100011;
    localparam logic [SW-1:0] E_NOP  = 23'b01100111000001110100001;
    localparam logic [SW-1:0] E_HLT  = 23'b00000011000001110000001;
    localparam logic [SW-1:0] E_INC  = 23'b01110110000000001100011;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic [OW-1:0] opcode;
    logic          stall;
    logic          flush;
    logic [SW-1:0] signals;
    logic          sig_valid;
    logic          imm_take;
    logic          illegal;
    logic          halted;
    logic [CW-1:0] instr_cnt;

    int passed = 0;
    int total  = 0;

    ctrl_unit_pipe #(.OPCODE_W(OW), .SIG_W(SW), .CNT_W(CW), .IMM_EN(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .stall       (stall),
        .flush       (flush),
        .signals     (signals),
        .sig_valid   (sig_valid),
        .imm_take    (imm_take),
        .illegal     (illegal),
        .halted      (halted),
        .instr_cnt   (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [SW-1:0] s, input logic sv,
                           input logic it, input logic il, input logic [CW-1:0] c);
        chk({tag, ".signals"},   32'(signals),   32'(s));
        chk({tag, ".sig_valid"}, 32'(sig_valid), 32'(sv));
        chk({tag, ".imm_take"},  32'(imm_take),  32'(it));
        chk({tag, ".illegal"},   32'(illegal),   32'(il));
        chk({tag, ".cnt"},       32'(instr_cnt), 32'(c));
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; opcode = '0; stall = 1'b0; flush = 1'b0;
        step();
        step();
        chk_out("reset", '0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("reset.halted", 32'(halted), 32'd0);
        reset = 1'b0;

        // ADD decode
        instr_valid = 1'b1; opcode = 7'b0000001;
        step();
        chk_out("add", E_ADD, 1'b1, 1'b0, 1'b0, 4'd1);

        // LDM, idle cycle in IMM, immediate beat, then SUB
        opcode = 7'b0110101;
        step();
        chk_out("ldm", E_LDM, 1'b1, 1'b0, 1'b0, 4'd2);
        instr_valid = 1'b0;
        step();
        chk_out("imm_wait", E_LDM, 1'b0, 1'b0, 1'b0, 4'd2);
        instr_valid = 1'b1; opcode = 7'b1010101;
        step();
        chk_out("imm_beat", E_LDM, 1'b0, 1'b1, 1'b0, 4'd2);
        opcode = 7'b0001001;
        step();
        chk_out("sub", E_SUB, 1'b1, 1'b0, 1'b0, 4'd3);

        // IADD, then flush (with stall) in IMM: bubble and back to RUN
        opcode = 7'b0100000;
        step();
        chk_out("iadd", E_IADD, 1'b1, 1'b0, 1'b0, 4'd4);
        flush = 1'b1; stall = 1'b1; opcode = 7'b0000011;
        step();
        chk_out("flush", '0, 1'b0, 1'b0, 1'b0, 4'd4);
        flush = 1'b0; stall = 1'b0; opcode = 7'b0010001;
        step();
        chk_out("not", E_NOT, 1'b1, 1'b0, 1'b0, 4'd5);

        // no beat: signals hold, pulses drop
        instr_valid = 1'b0;
        step();
        chk_out("idle", E_NOT, 1'b0, 1'b0, 1'b0, 4'd5);

        // illegal opcode
        instr_valid = 1'b1; opcode = 7'b1111111;
        step();
        chk_out("illegal", E_NOP, 1'b1, 1'b0, 1'b1, 4'd6);
        instr_valid = 1'b0;
        step();
        chk_out("illegal_drop", E_NOP, 1'b0, 1'b0, 1'b0, 4'd6);

        // HLT then 5 ignored ADD beats
        instr_valid = 1'b1; opcode = 7'b1100001;
        step();
        chk_out("hlt", E_HLT, 1'b1, 1'b0, 1'b0, 4'd7);
        opcode = 7'b0000001;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("halt_hold", E_HLT, 1'b0, 1'b0, 1'b0, 4'd7);
            chk("halt_hold.halted", 32'(halted), 32'd1);
        end

        // async reset leaves HALT
        #2 reset = 1'b1;
        #1;
        chk("rst_halt.halted", 32'(halted), 32'd0);
        chk_out("rst_halt", '0, 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        reset = 1'b0;

        // 17 back-to-back INCs with a 3-cycle stall mid-stream
        opcode = 7'b0000011; instr_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk_out("inc", E_INC, 1'b1, 1'b0, 1'b0, 4'(i));
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall", E_INC, 1'b1, 1'b0, 1'b0, 4'd8);
        end
        stall = 1'b0;
        for (int i = 9; i <= 17; i++) begin
            step();
            chk_out("inc2", E_INC, 1'b1, 1'b0, 1'b0, 4'(i % 16));
        end
        instr_valid = 1'b0;
        step();
        chk_out("end", E_INC, 1'b0, 1'b0, 1'b0, 4'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
